// File: rtl/ycr1_imem_wb_bridge.sv
// ycr1_imem_wb_bridge
//   Bridges the core instruction-memory request port onto a Wishbone master.
//   Requests are buffered in a 2-entry FIFO and serviced strictly in order,
//   with one Wishbone transfer outstanding at a time. Write commands are
//   rejected with an error response and never reach the bus. A transfer that
//   is neither acked nor errored within TIMEOUT_CYC bus cycles is aborted
//   and reported as an error.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req/cmd/addr             : request valid, 0=read 1=write, byte address
//   imem_req_ack                  : request accepted this cycle (queue not full)
//   imem_resp/imem_rdata          : 0 NOTRDY, 1 RDY_OK, 2 RDY_ER; read data
//   wb_cyc_o/stb_o/adr_o/we_o/sel_o : Wishbone master outputs (read-only)
//   wb_dat_i/ack_i/err_i          : Wishbone slave response
module ycr1_imem_wb_bridge #(
  parameter int TIMEOUT_CYC = 255,
  parameter int REQ_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic        imem_cmd,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  // Last BUS cycle index (counter starts at 0 on entry to BUS)
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;

  // Request FIFO
  logic [31:0] q_addr_q [REQ_DEPTH];
  logic        q_cmd_q  [REQ_DEPTH];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q;
  logic        push, pop, full, empty;
  logic [31:0] head_addr;
  logic        head_cmd;

  // Bus / response state
  logic [7:0]  wait_q, wait_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign head_addr = q_addr_q[rd_ptr_q];
  assign head_cmd  = q_cmd_q[rd_ptr_q];

  // Held low during reset even though the queue is already empty.
  assign imem_req_ack = ~full & ~rst;
  assign push         = imem_req & imem_req_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= imem_addr;
      q_cmd_q[wr_ptr_q]  <= imem_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 8'd0;
      adr_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    wait_d  = wait_q;
    adr_d   = adr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_cmd) begin
            // Writes are unsupported: answer with an error, skip the bus
            pop     = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = ST_RESP;
          end else begin
            adr_d   = head_addr & 32'hFFFF_FFFC;
            wait_d  = 8'd0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // err dominates ack; ack in the final allowed cycle still succeeds
        if (wb_err_i || (!wb_ack_i && (wait_q == TO_LAST))) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = ST_RESP;
        end else if (wb_ack_i) begin
          pop     = 1'b1;
          err_d   = 1'b0;
          rdata_d = wb_dat_i;
          state_d = ST_RESP;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      ST_RESP: begin
        // Chain straight into the next read to sustain 1 resp / 2 cycles
        if (!empty && !head_cmd) begin
          adr_d   = head_addr & 32'hFFFF_FFFC;
          wait_d  = 8'd0;
          state_d = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_cyc_o   = (state_q == ST_BUS);
  assign wb_stb_o   = (state_q == ST_BUS);
  assign wb_adr_o   = adr_q;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;
  assign imem_resp  = (state_q == ST_RESP) ? (err_q ? 2'd2 : 2'd1) : 2'd0;
  assign imem_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_ycr1_imem_wb_bridge.sv
module tb_ycr1_imem_wb_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_cmd;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  ycr1_imem_wb_bridge #(.TIMEOUT_CYC(TO), .REQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
    .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave behaviour for one read: respond after lat wait cycles;
  // kind 0 = ack with dat, 1 = err, 2 = never respond.
  typedef struct {logic [31:0] adr; int lat; int kind; logic [31:0] dat;} plan_t;
  typedef struct {logic [1:0] resp; logic [31:0] dat;} exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    resp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Expected number of stb cycles for a planned read
  function automatic int exp_len(input plan_t p);
    if (p.kind == 2) return TO;
    return (p.lat + 1 < TO) ? p.lat + 1 : TO;
  endfunction

  // ---------------- Wishbone slave model ----------------
  plan_t cur;
  logic  busy  = 1'b0;
  logic  bogus = 1'b0;
  int    remain, stb_n;

  always @(negedge clk) begin
    if (rst) begin
      busy     = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_cyc_o && wb_stb_o) begin
        if (!busy) begin
          bogus = (plan_q.size() == 0);
          if (bogus) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_cycle: adr %h with no read pending", wb_adr_o);
            cur = '{adr: 32'd0, lat: 0, kind: 2, dat: 32'd0};
          end else begin
            cur = plan_q.pop_front();
          end
          busy = 1'b1; remain = cur.lat; stb_n = 0;
        end
        stb_n++;
        if (!bogus) chk("wb_adr", wb_adr_o, cur.adr);
        if (remain == 0) begin
          if (cur.kind == 0) begin
            wb_ack_i = 1'b1; wb_dat_i = cur.dat;
          end else if (cur.kind == 1) begin
            wb_err_i = 1'b1; wb_ack_i = 1'($urandom_range(0, 1));
          end
        end else begin
          remain--;
        end
      end else begin
        if (busy) begin
          if (!bogus) chk("stb_cycles", 32'(stb_n), 32'(exp_len(cur)));
          busy = 1'b0;
        end
        // Stray responses outside a transfer must be ignored
        wb_ack_i = ($urandom_range(0, 3) == 0);
        wb_err_i = ($urandom_range(0, 5) == 0);
      end
    end
  end

  // ---------------- Response monitor ----------------
  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_resp = 1'b0;
    end else begin
      chk("wb_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
      if (imem_resp != 2'd0) begin
        if (prev_resp) begin
          checks++; errors++;
          $display("FAIL resp_width: response held for more than one cycle at %0d", cyc_cnt);
        end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp %0d rdata %h, none expected", imem_resp, imem_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("imem_resp", 32'(imem_resp), 32'(e.resp));
          chk("imem_rdata", imem_rdata, e.dat);
        end
        resp_cyc_q.push_back(cyc_cnt);
        prev_resp = 1'b1;
      end else begin
        chk("rdata_idle", imem_rdata, 32'd0);
        prev_resp = 1'b0;
      end
    end
  end

  // ---------------- Stimulus ----------------
  // Called at a negedge; returns at a negedge with imem_req dropped.
  task automatic issue(input logic cmd, input logic [31:0] addr, input int lat,
                       input int kind, input logic [31:0] dat,
                       output int acc_cyc, output int w);
    plan_t p;
    exp_t  e;
    w = 0;
    imem_req = 1'b1; imem_cmd = cmd; imem_addr = addr;
    while (!imem_req_ack && w < 300) begin
      @(negedge clk); w++;
    end
    acc_cyc = cyc_cnt;
    if (!imem_req_ack) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: addr %h never accepted", addr);
    end else if (cmd) begin
      e = '{resp: 2'd2, dat: 32'd0};
      exp_q.push_back(e);
    end else begin
      p = '{adr: addr & 32'hFFFF_FFFC, lat: lat, kind: kind, dat: dat};
      plan_q.push_back(p);
      if (kind == 0 && lat + 1 <= TO) e = '{resp: 2'd1, dat: dat};
      else                            e = '{resp: 2'd2, dat: 32'd0};
      exp_q.push_back(e);
    end
    @(negedge clk);
    imem_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin
      @(negedge clk); t++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int n, w, n3, w3, t;
    imem_req = 1'b0; imem_cmd = 1'b0; imem_addr = 32'd0;
    wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // Reset state
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_resp", 32'(imem_resp), 32'd0);
    chk("rst_rdata", imem_rdata, 32'd0);
    chk("rst_req_ack", 32'(imem_req_ack), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ack_after_rst", 32'(imem_req_ack), 32'd1);

    // Single zero-wait read: response three cycles after acceptance
    resp_cyc_q.delete();
    issue(1'b0, 32'h0001_0004, 0, 0, 32'hDEAD_BEEF, n, w);
    drain();
    if (resp_cyc_q.size() == 1) chk("single_read_latency", 32'(resp_cyc_q[0]), 32'(n + 3));
    else chk("single_read_resp_count", 32'(resp_cyc_q.size()), 32'd1);

    // Unaligned address, write rejection, then a normal read
    issue(1'b0, 32'h0001_0006, 1, 0, 32'h1234_5678, n, w);
    issue(1'b1, 32'h0000_0100, 0, 0, 32'd0, n, w);
    issue(1'b0, 32'h0000_0200, 2, 0, 32'hCAFE_F00D, n, w);
    drain();

    // Timeout, err pulse, ack in last allowed cycle, ack one cycle too late
    issue(1'b0, 32'h0000_1000, 0, 2, 32'd0, n, w);
    issue(1'b0, 32'h0000_1004, 1, 1, 32'd0, n, w);
    issue(1'b0, 32'h0000_1008, TO - 1, 0, 32'hA5A5_5A5A, n, w);
    issue(1'b0, 32'h0000_100C, TO, 0, 32'h0F0F_F0F0, n, w);
    drain();

    // Queue full: third request waits until the first entry is popped
    resp_cyc_q.delete();
    issue(1'b0, 32'h0000_2000, 3, 0, 32'h1111_1111, n, w);
    issue(1'b0, 32'h0000_2004, 3, 0, 32'h2222_2222, n, w);
    issue(1'b0, 32'h0000_2008, 3, 0, 32'h3333_3333, n3, w3);
    chk("third_req_blocked", 32'(w3 > 0), 32'd1);
    if (resp_cyc_q.size() > 0) chk("third_accept_at_pop", 32'(n3), 32'(resp_cyc_q[0]));
    else chk("first_resp_before_third_accept", 32'(resp_cyc_q.size()), 32'd1);
    drain();

    // Back-to-back zero-wait reads: one response every two cycles
    resp_cyc_q.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h0000_3000 + 32'(i * 4), 0, 0, $urandom, n, w);
    drain();
    chk("b2b_resp_count", 32'(resp_cyc_q.size()), 32'd4);
    if (resp_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_resp_spacing", 32'(resp_cyc_q[i] - resp_cyc_q[i-1]), 32'd2);

    // Reset during a bus transfer with another read queued behind it
    issue(1'b0, 32'h0000_4000, 0, 2, 32'd0, n, w);
    issue(1'b0, 32'h0000_4004, 0, 0, 32'h4444_4444, n, w);
    t = 0;
    while (!wb_stb_o && t < 20) begin @(negedge clk); t++; end
    chk("stb_before_rst", 32'(wb_stb_o), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb", 32'(wb_stb_o), 32'd0);
    chk("midrst_req_ack", 32'(imem_req_ack), 32'd0);
    chk("midrst_resp", 32'(imem_resp), 32'd0);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_queue_empty", 32'(imem_req_ack), 32'd1);
    chk("postrst_no_stb", 32'(wb_stb_o), 32'd0);
    issue(1'b0, 32'h0000_5004, 1, 0, 32'h5555_AAAA, n, w);
    drain();

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      issue(1'($urandom_range(0, 4) == 0), $urandom, int'($urandom_range(0, 5)),
            (k < 7) ? 0 : (k < 9) ? 1 : 2, $urandom, n, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
